// File: rtl/mgmt_rx_frame_reader.sv
// mgmt_rx_frame_reader
// Pops one frame length from the header FIFO, then returns that frame's 32-bit words
// to the host one request at a time. If the host discards the frame, the words it has
// not read are popped and dropped.
// Optional build macro MGMT_RX_FRAME_READER_COUNTERS_EN adds the saturating
// frames_read / frames_discarded statistics outputs.
module mgmt_rx_frame_reader (
    input  logic        sys_clk,
    input  logic        rst,
    output logic        rxheader_rd_en,
    input  logic        rxheader_rd_empty,
    input  logic [10:0] rxheader_rd_data,
    output logic        rxfifo_rd_en,
    output logic        rxfifo_rd_pop_single,
    input  logic [31:0] rxfifo_rd_data,
    output logic        frame_ready,
    output logic [10:0] frame_len,
    input  logic        word_rd,
    output logic        word_valid,
    output logic [31:0] word_data,
    input  logic        frame_discard,
    output logic        frame_done
`ifdef MGMT_RX_FRAME_READER_COUNTERS_EN
    ,
    output logic [31:0] frames_read,
    output logic [31:0] frames_discarded
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_WAIT,
        READY,
        FETCH,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [8:0]  words_left;
    logic [8:0]  words_left_next;
    logic [10:0] frame_len_next;
    logic        frame_ready_next;
    logic        zero_done;
    logic        zero_done_next;
    logic        done_now;

    // State register; reset parks the reader in IDLE without touching the FIFOs
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the FIFO/host strobes; the header pop is held off while rst is high
    always_comb begin
        state_next           = state;
        rxheader_rd_en       = 1'b0;
        rxfifo_rd_en         = 1'b0;
        rxfifo_rd_pop_single = 1'b0;
        word_valid           = 1'b0;
        word_data            = '0;
        done_now             = 1'b0;
        words_left_next      = words_left;
        frame_len_next       = frame_len;
        frame_ready_next     = frame_ready;
        zero_done_next       = 1'b0;

        case (state)
            IDLE: begin
                if (!rxheader_rd_empty && !rst) begin
                    rxheader_rd_en = 1'b1;
                    state_next     = HDR_WAIT;
                end
            end

            HDR_WAIT: begin
                frame_len_next  = rxheader_rd_data;
                words_left_next = 9'(({1'b0, rxheader_rd_data} + 12'd3) >> 2);
                if (rxheader_rd_data == 11'd0) begin
                    zero_done_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    frame_ready_next = 1'b1;
                    state_next       = READY;
                end
            end

            READY: begin
                if (frame_discard) begin
                    frame_ready_next = 1'b0;
                    state_next       = DRAIN;
                end else if (word_rd && (words_left != 9'd0)) begin
                    rxfifo_rd_en         = 1'b1;
                    rxfifo_rd_pop_single = 1'b1;
                    words_left_next      = words_left - 9'd1;
                    state_next           = FETCH;
                end
            end

            FETCH: begin
                word_valid = 1'b1;
                word_data  = rxfifo_rd_data;
                if (words_left == 9'd0) begin
                    done_now         = 1'b1;
                    frame_ready_next = 1'b0;
                    state_next       = IDLE;
                end else begin
                    state_next = READY;
                end
            end

            DRAIN: begin
                if (words_left != 9'd0) begin
                    rxfifo_rd_pop_single = 1'b1;
                    words_left_next      = words_left - 9'd1;
                end else begin
                    done_now   = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame bookkeeping: latched length, remaining word count, ready flag and zero-length done pulse
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            frame_len   <= '0;
            words_left  <= '0;
            frame_ready <= 1'b0;
            zero_done   <= 1'b0;
        end else begin
            frame_len   <= frame_len_next;
            words_left  <= words_left_next;
            frame_ready <= frame_ready_next;
            zero_done   <= zero_done_next;
        end
    end

    // A zero-length header finishes one cycle later than the decision in HDR_WAIT
    assign frame_done = done_now | zero_done;

`ifdef MGMT_RX_FRAME_READER_COUNTERS_EN
    logic read_done;
    logic discard_done;

    assign read_done    = (state == FETCH) && (words_left == 9'd0);
    assign discard_done = ((state == DRAIN) && (words_left == 9'd0)) || zero_done;

    // Saturating statistics: frames fully read versus frames dropped or empty
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            frames_read      <= '0;
            frames_discarded <= '0;
        end else begin
            if (read_done && (frames_read != 32'hFFFF_FFFF)) begin
                frames_read <= frames_read + 32'd1;
            end
            if (discard_done && (frames_discarded != 32'hFFFF_FFFF)) begin
                frames_discarded <= frames_discarded + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mgmt_rx_frame_reader.sv
// tb_mgmt_rx_frame_reader
// Drives mgmt_rx_frame_reader from emulated header/data FIFOs and a scripted host,
// and compares every returned word, strobe and timing against a frame-level model.
// Build with MGMT_RX_FRAME_READER_COUNTERS_EN to also check the statistics outputs.
module tb_mgmt_rx_frame_reader;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxheader_rd_en;
    logic        rxheader_rd_empty = 1'b1;
    logic [10:0] rxheader_rd_data = '0;
    logic        rxfifo_rd_en;
    logic        rxfifo_rd_pop_single;
    logic [31:0] rxfifo_rd_data = '0;
    logic        frame_ready;
    logic [10:0] frame_len;
    logic        word_rd = 1'b0;
    logic        word_valid;
    logic [31:0] word_data;
    logic        frame_discard = 1'b0;
    logic        frame_done;
`ifdef MGMT_RX_FRAME_READER_COUNTERS_EN
    logic [31:0] frames_read;
    logic [31:0] frames_discarded;
`endif

    // Free-running 100 MHz clock
    always #5 sys_clk = ~sys_clk;

    mgmt_rx_frame_reader dut (
        .sys_clk              (sys_clk),
        .rst                  (rst),
        .rxheader_rd_en       (rxheader_rd_en),
        .rxheader_rd_empty    (rxheader_rd_empty),
        .rxheader_rd_data     (rxheader_rd_data),
        .rxfifo_rd_en         (rxfifo_rd_en),
        .rxfifo_rd_pop_single (rxfifo_rd_pop_single),
        .rxfifo_rd_data       (rxfifo_rd_data),
        .frame_ready          (frame_ready),
        .frame_len            (frame_len),
        .word_rd              (word_rd),
        .word_valid           (word_valid),
        .word_data            (word_data),
        .frame_discard        (frame_discard),
        .frame_done           (frame_done)
`ifdef MGMT_RX_FRAME_READER_COUNTERS_EN
        ,
        .frames_read          (frames_read),
        .frames_discarded     (frames_discarded)
`endif
    );

    typedef struct {
        int len;
        int base;
    } frame_t;

    int          checks = 0;
    int          failures = 0;
    int          cycle_no = 0;
    int          pops = 0;
    int          hdr_pops = 0;
    int          valids = 0;
    int          exp_valids = 0;
    int          exp_read = 0;
    int          exp_disc = 0;
    int          last_hdr_cycle = -1;
    logic [10:0] hdr_q[$];
    logic [31:0] data_q[$];
    logic [31:0] golden[$];
    frame_t      frame_q[$];

    logic        o_hdr_rd_en = 1'b0;
    logic        o_empty = 1'b1;
    logic        o_fifo_rd_en = 1'b0;
    logic        o_pop = 1'b0;
    logic        o_ready = 1'b0;
    logic        o_valid = 1'b0;
    logic        o_done = 1'b0;
    logic [10:0] o_len = '0;
    logic [31:0] o_data = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cycle_no);
        end
    endtask

    // One clock cycle: apply host inputs, sample outputs, then let the emulated FIFOs react to pops
    task automatic applyStimulus(input logic rd, input logic disc);
        word_rd       = rd;
        frame_discard = disc;
        #1;
        o_hdr_rd_en  = rxheader_rd_en;
        o_empty      = rxheader_rd_empty;
        o_fifo_rd_en = rxfifo_rd_en;
        o_pop        = rxfifo_rd_pop_single;
        o_ready      = frame_ready;
        o_valid      = word_valid;
        o_done       = frame_done;
        o_len        = frame_len;
        o_data       = word_data;
        if (o_hdr_rd_en) begin
            last_hdr_cycle = cycle_no;
            hdr_pops++;
        end
        if (o_pop) pops++;
        if (o_valid) valids++;
        @(posedge sys_clk);
        #1;
        if (o_hdr_rd_en) begin
            if (hdr_q.size() > 0) rxheader_rd_data = hdr_q.pop_front();
            rxheader_rd_empty = (hdr_q.size() == 0);
        end
        if (o_pop) begin
            if (data_q.size() > 0) rxfifo_rd_data = data_q.pop_front();
            else rxfifo_rd_data = 32'hDEAD_BEEF;
        end
        @(negedge sys_clk);
        word_rd       = 1'b0;
        frame_discard = 1'b0;
        cycle_no++;
    endtask

    task automatic pushFrame(input int len);
        frame_t f;
        f.len  = len;
        f.base = golden.size();
        for (int i = 0; i < (len + 3) / 4; i++) begin
            golden.push_back($urandom);
            data_q.push_back(golden[golden.size() - 1]);
        end
        frame_q.push_back(f);
        hdr_q.push_back(11'(len));
        rxheader_rd_empty = 1'b0;
    endtask

    // Host side of one frame: read words until discard_after, then discard (optionally with word_rd)
    task automatic consumeFrame(input int discard_after, input logic with_rd, input int spacing);
        frame_t f;
        int     n;
        int     pops_start;
        int     done_cycle;
        int     prev_hdr;
        int     drained;
        int     bad;
        int     j;
        logic   seen;
        logic   hdr_pending;

        f          = frame_q.pop_front();
        n          = (f.len + 3) / 4;
        pops_start = pops;
        done_cycle = -1;
        if (f.len == 0) begin
            seen     = 1'b0;
            prev_hdr = last_hdr_cycle;
            for (int k = 0; k < 40 && done_cycle < 0; k++) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if (o_ready) seen = 1'b1;
                if (o_done) done_cycle = cycle_no - 1;
                else prev_hdr = last_hdr_cycle;
            end
            checkOutput("zero_len_done_seen", 32'(done_cycle >= 0), 32'd1);
            checkOutput("zero_len_done_delay", 32'(done_cycle - prev_hdr), 32'd2);
            checkOutput("zero_len_never_ready", 32'(seen), 32'd0);
            checkOutput("zero_len_frame_len", 32'(o_len), 32'd0);
            hdr_pending = !o_empty;
            if (hdr_pending) checkOutput("next_hdr_pop_after_zero", 32'(last_hdr_cycle), 32'(done_cycle));
            exp_disc++;
        end else begin
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                applyStimulus(1'b0, 1'b0);
                if (o_ready === 1'b1) seen = 1'b1;
            end
            checkOutput("ready_seen", 32'(seen), 32'd1);
            checkOutput("frame_len_at_ready", 32'(o_len), 32'(f.len));
            j = 0;
            while (j < n && j != discard_after) begin
                applyStimulus(1'b1, 1'b0);
                checkOutput("fetch_rd_en", 32'(o_fifo_rd_en), 32'd1);
                checkOutput("fetch_pop", 32'(o_pop), 32'd1);
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                checkOutput("word_valid", 32'(o_valid), 32'd1);
                checkOutput("word_data", o_data, golden[f.base + j]);
                checkOutput("frame_len_stable", 32'(o_len), 32'(f.len));
                checkOutput("frame_done_on_last", 32'(o_done), 32'(j == n - 1));
                exp_valids++;
                if (j == n - 1) done_cycle = cycle_no - 1;
                j++;
                for (int s = 2; s < spacing && j < n; s++) applyStimulus(1'b0, 1'b0);
            end
            if (j < n) begin
                applyStimulus(with_rd, 1'b1);
                checkOutput("discard_no_fetch", 32'(o_fifo_rd_en), 32'd0);
                checkOutput("discard_no_pop_same_cycle", 32'(o_pop), 32'd0);
                drained = 0;
                bad     = 0;
                for (int k = 0; k < n + 8 && done_cycle < 0; k++) begin
                    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if (o_valid || o_ready) bad++;
                    if (o_done) done_cycle = cycle_no - 1;
                    else if (o_pop && !o_fifo_rd_en) drained++;
                    else bad++;
                end
                checkOutput("drain_done_seen", 32'(done_cycle >= 0), 32'd1);
                checkOutput("drain_pop_count", 32'(drained), 32'(n - j));
                checkOutput("drain_glitches", 32'(bad), 32'd0);
                exp_disc++;
            end else begin
                exp_read++;
            end
            hdr_pending = !o_empty;
            applyStimulus(1'b0, 1'b0);
            checkOutput("ready_low_after_done", 32'(o_ready), 32'd0);
            if (hdr_pending) checkOutput("next_hdr_pop_in_idle", 32'(last_hdr_cycle), 32'(done_cycle + 1));
        end
        checkOutput("done_single_cycle", 32'(o_done && (f.len != 0)), 32'd0);
        checkOutput("frame_pop_total", 32'(pops - pops_start), 32'(n));
    endtask

    // Bounded run time; a hang is reported and the run stopped
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed frames, mid-frame reset, randomized frames
    initial begin
        logic seen;
        int   pops_before;
        int   hdr_before;
        int   len;
        int   n;
        int   nframes;

        @(negedge sys_clk);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("reset_hdr_rd_en", 32'(o_hdr_rd_en), 32'd0);
        checkOutput("reset_fifo_rd_en", 32'(o_fifo_rd_en), 32'd0);
        checkOutput("reset_pop_single", 32'(o_pop), 32'd0);
        checkOutput("reset_frame_ready", 32'(o_ready), 32'd0);
        checkOutput("reset_frame_len", 32'(o_len), 32'd0);
        checkOutput("reset_word_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_word_data", o_data, 32'd0);
        checkOutput("reset_frame_done", 32'(o_done), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);

        $display("[TB] directed frames");
        pushFrame(60);
        consumeFrame(1000, 1'b0, 3);
        pushFrame(61);
        consumeFrame(1000, 1'b0, 2);
        pushFrame(1500);
        pushFrame(8);
        consumeFrame(10, 1'b0, 2);
        consumeFrame(1000, 1'b0, 2);
        pushFrame(0);
        pushFrame(4);
        consumeFrame(1000, 1'b0, 2);
        consumeFrame(1000, 1'b0, 2);
        pushFrame(20);
        consumeFrame(2, 1'b1, 2);
        pushFrame(2044);
        consumeFrame(0, 1'b1, 2);

        $display("[TB] reset during a word fetch");
        pushFrame(40);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            applyStimulus(1'b0, 1'b0);
            if (o_ready === 1'b1) seen = 1'b1;
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        exp_valids++;
        applyStimulus(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_frame_ready", 32'(frame_ready), 32'd0);
        checkOutput("midrst_frame_len", 32'(frame_len), 32'd0);
        checkOutput("midrst_word_valid", 32'(word_valid), 32'd0);
        checkOutput("midrst_word_data", word_data, 32'd0);
        checkOutput("midrst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("midrst_strobes", 32'({rxheader_rd_en, rxfifo_rd_en, rxfifo_rd_pop_single}), 32'd0);
        hdr_q.delete();
        data_q.delete();
        frame_q.delete();
        rxheader_rd_empty = 1'b1;
        exp_read = 0;
        exp_disc = 0;
        pushFrame(24);
        pops_before = pops;
        hdr_before  = hdr_pops;
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1);
        checkOutput("midrst_no_data_pops", 32'(pops - pops_before), 32'd0);
        checkOutput("midrst_no_hdr_pops", 32'(hdr_pops - hdr_before), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_rst_hdr_pop", 32'(o_hdr_rd_en), 32'd1);
        consumeFrame(1000, 1'b0, 2);

        $display("[TB] randomized frames");
        for (int it = 0; it < 25; it++) begin
            nframes = $urandom_range(1, 2);
            for (int f = 0; f < nframes; f++) begin
                case ($urandom_range(0, 9))
                    0:       len = 0;
                    1:       len = $urandom_range(1900, 2044);
                    default: len = $urandom_range(1, 200);
                endcase
                pushFrame(len);
            end
            for (int f = 0; f < nframes; f++) begin
                n = (frame_q[0].len + 3) / 4;
                if (n > 100) consumeFrame($urandom_range(0, 20), 1'($urandom_range(0, 1)), $urandom_range(2, 4));
                else if (n > 0 && $urandom_range(0, 2) == 0) consumeFrame($urandom_range(0, n - 1), 1'($urandom_range(0, 1)), $urandom_range(2, 4));
                else consumeFrame(1000, 1'b0, $urandom_range(2, 4));
            end
        end

        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("total_word_valid", 32'(valids), 32'(exp_valids));
`ifdef MGMT_RX_FRAME_READER_COUNTERS_EN
        checkOutput("frames_read", frames_read, 32'(exp_read));
        checkOutput("frames_discarded", frames_discarded, 32'(exp_disc));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
